// File: rtl/ram_pingpong_ctrl_pkg.sv
// Shared interleaver definitions: bank count and the per-bank fill/drain state.
package ram_pingpong_ctrl_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic bank_readable(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/ram_pingpong_ctrl_skid_fifo2.sv
// Two-entry output FIFO holding returned read data and its block-end tag.
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   count
);

  logic [W:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       pop;

  // The head is read straight out of storage, so it holds steady while stalled.
  always_comb begin
    out_valid = (cnt != 2'd0);
    pop       = out_valid && pop_ready;
    out_data  = mem[rd_ptr][W-1:0];
    out_last  = mem[rd_ptr][W];
    count     = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_pingpong_ctrl.sv
// Ping-pong bank controller: linear writes into one bank while the other is
// read back in permuted order through an external address table.
module ram_pingpong_ctrl
  import ram_pingpong_ctrl_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] blk_len_m1,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  output logic [A_WIDTH-1:0] rd_idx,
  input  logic [A_WIDTH-1:0] il_addr,
  output logic [1:0]         wen,
  output logic [A_WIDTH-1:0] waddr,
  output logic [D_WIDTH-1:0] wdata,
  output logic [1:0]         ren,
  output logic [A_WIDTH-1:0] raddr,
  input  logic [D_WIDTH-1:0] rdata0,
  input  logic [D_WIDTH-1:0] rdata1
);

  bank_state_t        bstate [NUM_BANKS];
  logic [A_WIDTH-1:0] len_q  [NUM_BANKS];
  logic               wbank;
  logic               rbank;
  logic [A_WIDTH-1:0] wcnt;
  logic [A_WIDTH-1:0] rcnt;
  logic               inflight;
  logic               inflight_bank;
  logic               inflight_last;

  logic               wr_fire;
  logic               wr_last;
  logic [A_WIDTH-1:0] wr_len;
  logic               rd_fire;
  logic               rd_last;
  logic [2:0]         occ;
  logic [1:0]         fifo_count;
  logic               fifo_pop;
  logic [D_WIDTH-1:0] ret_data;

  // A bank's length is only latched on its first write, so an EMPTY bank
  // compares against the live input instead.
  always_comb begin
    wr_len   = (bstate[wbank] == BANK_EMPTY) ? blk_len_m1 : len_q[wbank];
    in_ready = bank_writable(bstate[wbank]);
    wr_fire  = in_valid && in_ready;
    wr_last  = wr_fire && (wcnt == wr_len);
    wen      = 2'b00;
    if (wr_fire) wen[wbank] = 1'b1;
    waddr    = wcnt;
    wdata    = in_data;

    fifo_pop = out_valid && out_ready;
    occ      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, fifo_pop};
    rd_fire  = bank_readable(bstate[rbank]) && (occ < 3'd2);
    rd_last  = rd_fire && (rcnt == len_q[rbank]);
    ren      = 2'b00;
    if (rd_fire) ren[rbank] = 1'b1;
    raddr    = il_addr;
    rd_idx   = rcnt;
    ret_data = inflight_bank ? rdata1 : rdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bstate[b] <= BANK_EMPTY;
        len_q[b]  <= '0;
      end
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wcnt          <= '0;
      rcnt          <= '0;
      inflight      <= 1'b0;
      inflight_bank <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (bstate[wbank] == BANK_EMPTY) len_q[wbank] <= blk_len_m1;
        if (wr_last) begin
          bstate[wbank] <= BANK_FULL;
          wcnt          <= '0;
          wbank         <= ~wbank;
        end else begin
          bstate[wbank] <= BANK_FILLING;
          wcnt          <= wcnt + 1'b1;
        end
      end
      // Reader and writer never own the same bank, so both updates can land
      // on one edge without conflict.
      if (rd_fire) begin
        if (rd_last) begin
          bstate[rbank] <= BANK_EMPTY;
          rcnt          <= '0;
          rbank         <= ~rbank;
        end else begin
          bstate[rbank] <= BANK_DRAINING;
          rcnt          <= rcnt + 1'b1;
        end
      end
      inflight      <= rd_fire;
      inflight_bank <= rbank;
      inflight_last <= rd_last;
    end
  end

  skid_fifo2 #(.W(D_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (ret_data),
    .push_last (inflight_last),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_count)
  );

endmodule
